num_display_ctrl: RTL and testbench



---
 rtl/num_display_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_num_display_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/num_display_ctrl.sv
// Round-robin sharing of a 4-digit multiplexed 7-segment display between two requesters,
// with shift-add-3 BCD conversion. Define NUM_DISPLAY_LZB_EN for leading-zero blanking.
module num_display_ctrl #(
  parameter int unsigned SCAN_DIV    = 1000,
  parameter int unsigned HOLD_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  output logic [1:0]  gnt,
  output logic        busy,
  output logic [7:0]  led,
  output logic [3:0]  state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_SHOW    = 2'd2;

  localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [1:0]        fsm_q, fsm_d;
  logic              ptr_q, ptr_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [31:0]       sr_q, sr_d;
  logic [3:0]        conv_q, conv_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       dig_q, dig_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [3:0]        scan_q, scan_d;
  logic [7:0]        led_q, led_d;

  logic [31:0] sr_adj, sr_shift;
  logic        win;
  logic [15:0] win_val;
  logic        tick;
  logic [3:0]  scan_nxt;
  logic [1:0]  pos;
  logic        pos_valid;
  logic [3:0]  blank;
  logic [7:0]  led_nxt;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'b00000011;
      4'd1:    seg7 = 8'b10011111;
      4'd2:    seg7 = 8'b00100101;
      4'd3:    seg7 = 8'b00001101;
      4'd4:    seg7 = 8'b10011001;
      4'd5:    seg7 = 8'b01001001;
      4'd6:    seg7 = 8'b01000001;
      4'd7:    seg7 = 8'b00011011;
      4'd8:    seg7 = 8'b00000001;
      4'd9:    seg7 = 8'b00011001;
      default: seg7 = 8'b11111110;
    endcase
  endfunction

  // One double-dabble step: correct every BCD nibble, then shift the whole register left.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < 4; i++) begin
      if (sr_q[16+4*i +: 4] >= 4'd5) sr_adj[16+4*i +: 4] = sr_q[16+4*i +: 4] + 4'd3;
    end
    sr_shift = {sr_adj[30:0], 1'b0};
  end

  // NOTE: every variable gets a default at the top of the block so no path infers a latch.
  always_comb begin
    fsm_d      = fsm_q;
    ptr_d      = ptr_q;
    gnt_d      = 2'b00;
    sr_d       = sr_q;
    conv_d     = conv_q;
    hold_d     = hold_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    dig_d      = dig_q;
    win        = (req == 2'b11) ? ptr_q : req[1];
    win_val    = win ? val1 : val0;
    case (fsm_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          gnt_d      = win ? 2'b10 : 2'b01;
          sr_d       = {16'd0, win_val};
          ovf_pend_d = (win_val > 16'd9999);
          ptr_d      = ~win;
          conv_d     = 4'd0;
          fsm_d      = S_CONVERT;
        end
      end
      S_CONVERT: begin
        sr_d   = sr_shift;
        conv_d = conv_q + 4'd1;
        if (conv_q == 4'd15) begin
          ovf_d = ovf_pend_q;
          if (!ovf_pend_q) dig_d = sr_shift[31:16];
          hold_d = '0;
          fsm_d  = S_SHOW;
        end
      end
      S_SHOW: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          fsm_d  = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    tick = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DIV_W'(1);
    case (scan_q)
      4'b1111: scan_nxt = 4'b1110;
      4'b1110: scan_nxt = 4'b1101;
      4'b1101: scan_nxt = 4'b1011;
      4'b1011: scan_nxt = 4'b0111;
      4'b0111: scan_nxt = 4'b1110;
      default: scan_nxt = 4'b1111;
    endcase
    pos_valid = 1'b1;
    case (scan_nxt)
      4'b1110: pos = 2'd0;
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      default: begin pos = 2'd0; pos_valid = 1'b0; end
    endcase
`ifdef NUM_DISPLAY_LZB_EN
    blank[3] = (dig_q[15:12] == 4'd0);
    blank[2] = blank[3] && (dig_q[11:8] == 4'd0);
    blank[1] = blank[2] && (dig_q[7:4] == 4'd0);
    blank[0] = 1'b0;
`else
    blank = 4'b0000;
`endif
    if (!pos_valid)      led_nxt = 8'b11111111;
    else if (ovf_q)      led_nxt = 8'b11111101;
    else if (blank[pos]) led_nxt = 8'b11111111;
    else                 led_nxt = seg7(dig_q[4*pos +: 4]);
    scan_d = tick ? scan_nxt : scan_q;
    led_d  = tick ? led_nxt : led_q;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= S_IDLE;
      ptr_q      <= 1'b0;
      gnt_q      <= 2'b00;
      sr_q       <= '0;
      conv_q     <= '0;
      hold_q     <= '0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      dig_q      <= '0;
      div_q      <= '0;
      scan_q     <= 4'b1111;
      led_q      <= 8'b11111111;
    end else begin
      fsm_q      <= fsm_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      sr_q       <= sr_d;
      conv_q     <= conv_d;
      hold_q     <= hold_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      dig_q      <= dig_d;
      div_q      <= div_d;
      scan_q     <= scan_d;
      led_q      <= led_d;
    end
  end

  assign gnt   = gnt_q;
  assign busy  = (fsm_q != S_IDLE);
  assign led   = led_q;
  assign state = scan_q;

endmodule

// File: tb/tb_num_display_ctrl.sv
// Directed scoreboard bench for num_display_ctrl (SCAN_DIV=4, HOLD_CYCLES=20).
module tb_num_display_ctrl;

  localparam int SCAN = 4;
  localparam int HOLD = 20;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] val0, val1;
  logic [1:0]  gnt;
  logic        busy;
  logic [7:0]  led;
  logic [3:0]  state;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  sb_t sb_q[$];

  num_display_ctrl #(.SCAN_DIV(SCAN), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .val0(val0), .val1(val1),
    .gnt(gnt), .busy(busy), .led(led), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'b00000011;
      1: return 8'b10011111;
      2: return 8'b00100101;
      3: return 8'b00001101;
      4: return 8'b10011001;
      5: return 8'b01001001;
      6: return 8'b01000001;
      7: return 8'b00011011;
      8: return 8'b00000001;
      9: return 8'b00011001;
      default: return 8'b11111110;
    endcase
  endfunction

  // Expected pattern per digit position (index 0 = ones) for a displayed value.
  function automatic logic [3:0][7:0] exp_disp(input int v);
    logic [3:0][7:0] r;
    int p;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r[i] = (v > 9999) ? 8'b11111101 : seg_of((v / p) % 10);
      p = p * 10;
    end
`ifdef NUM_DISPLAY_LZB_EN
    if (v <= 9999) begin
      if (v < 1000) r[3] = 8'hFF;
      if (v < 100)  r[2] = 8'hFF;
      if (v < 10)   r[1] = 8'hFF;
    end
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input logic [15:0] obs);
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: observed %h expected no output", obs);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic wait_gnt(output logic [1:0] g);
    g = 2'b00;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        g = gnt;
        break;
      end
    end
  endtask

  task automatic do_grant(input string tag, input logic [1:0] r, input logic [15:0] v0,
                          input logic [15:0] v1, input logic [1:0] exp_g, input bit keep);
    logic [1:0] g;
    req = r; val0 = v0; val1 = v1;
    sb_q.push_back('{{tag, "_gnt"}, 16'(exp_g)});
    wait_gnt(g);
    pop_check(16'(g));
    if (!keep) req = 2'b00;
  endtask

  task automatic check_busy(input string tag);
    int n;
    n = 1;
    check({tag, "_busy_at_gnt"}, 16'(busy), 16'd1);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k == 0) check({tag, "_gnt_pulse"}, 16'(gnt), 16'd0);
      if (!busy) break;
      n++;
    end
    check({tag, "_busy_len"}, 16'(n), 16'(16 + HOLD));
  endtask

  task automatic show_check(input string tag, input int v);
    logic [3:0][7:0] e, seen_led;
    logic [3:0] seen;
    e = exp_disp(v);
    for (int i = 0; i < 4; i++) sb_q.push_back('{{tag, $sformatf("_dig%0d", i)}, 16'(e[i])});
    seen = 4'b0000;
    seen_led = '1;
    repeat (40) @(negedge clk);
    for (int k = 0; k < 5 * SCAN; k++) begin
      @(negedge clk);
      case (state)
        4'b1110: begin seen_led[0] = led; seen[0] = 1'b1; end
        4'b1101: begin seen_led[1] = led; seen[1] = 1'b1; end
        4'b1011: begin seen_led[2] = led; seen[2] = 1'b1; end
        4'b0111: begin seen_led[3] = led; seen[3] = 1'b1; end
        default: ;
      endcase
    end
    check({tag, "_scan_seen"}, 16'(seen), 16'hF);
    for (int i = 0; i < 4; i++) pop_check(16'(seen_led[i]));
  endtask

  initial begin
    int k, t0;
    logic bad;
    rst = 1'b1; req = 2'b00; val0 = '0; val1 = '0;

    repeat (3) @(negedge clk);
    check("rst_state", 16'(state), 16'hF);
    check("rst_led", 16'(led), 16'hFF);
    check("rst_gnt", 16'(gnt), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    rst = 1'b0;

    k = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      k = j;
      if (state != 4'b1111) break;
    end
    check("first_tick_cycles", 16'(k), 16'(SCAN));
    check("first_tick_state", 16'(state), 16'b1110);
    check("first_tick_led", 16'(led), 16'b00000011);

    do_grant("v1234", 2'b01, 16'd1234, 16'd0, 2'b01, 1'b0);
    check_busy("v1234");
    show_check("v1234", 1234);

    do_grant("v10000", 2'b10, 16'd0, 16'd10000, 2'b10, 1'b0);
    check_busy("v10000");
    show_check("v10000", 10000);

    do_grant("v9999", 2'b01, 16'd9999, 16'd0, 2'b01, 1'b0);
    check_busy("v9999");
    show_check("v9999", 9999);

    // Abort a conversion at its 8th cycle; the grant pointer must also return to requester 0.
    do_grant("abort", 2'b01, 16'd5555, 16'd0, 2'b01, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_gnt", 16'(gnt), 16'd0);
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_state", 16'(state), 16'hF);
    rst = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (gnt != 2'b00 || busy) bad = 1'b1;
    end
    check("abort_quiet", 16'(bad), 16'd0);
    show_check("abort", 0);

    do_grant("alt0", 2'b11, 16'd1, 16'd2, 2'b01, 1'b1);
    t0 = cyc;
    do_grant("alt1", 2'b11, 16'd1, 16'd2, 2'b10, 1'b1);
    check("alt1_sep", 16'(cyc - t0), 16'(16 + HOLD + 1));
    t0 = cyc;
    do_grant("alt2", 2'b11, 16'd1, 16'd2, 2'b01, 1'b0);
    check("alt2_sep", 16'(cyc - t0), 16'(16 + HOLD + 1));

    do_grant("v42", 2'b01, 16'd42, 16'd0, 2'b01, 1'b0);
    check_busy("v42");
    show_check("v42", 42);

    check("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
